// File: rtl/gcd_arb_pkg.sv
// Shared state encoding and constants for the gcd request arbiter.
package gcd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int JOB_CNT_W = 16;

endpackage

// File: rtl/gcd_rr_pick.sv
// Round-robin requester search: first set request at or above the pointer, wrapping modulo NREQ.
module gcd_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_rr_ptr,
    output logic [IDXW-1:0] o_gnt,
    output logic            o_any
);

    localparam logic [IDXW:0] NREQ_L = (IDXW + 1)'(NREQ);

    logic [IDXW:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest hit overrides earlier ones.
    always_comb begin
        o_gnt = '0;
        o_any = 1'b0;
        w_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_idx = {1'b0, i_rr_ptr} + (IDXW + 1)'(i);
            if (w_idx >= NREQ_L) begin
                w_idx = w_idx - NREQ_L;
            end
            if (i_req[w_idx[IDXW-1:0]]) begin
                o_gnt = w_idx[IDXW-1:0];
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one gcd engine among NREQ requesters; one job in flight, round-robin grants.
module gcd_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*W-1:0]    req_a,
    input  logic [NREQ*W-1:0]    req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [W-1:0]         rsp_res,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [W-1:0]         eng_a,
    output logic [W-1:0]         eng_b,
    output logic                 eng_start,
    input  logic                 eng_res_rdy,
    input  logic [W-1:0]         eng_res,
    output logic                 eng_res_fetch,
    output logic                 busy,
    output logic [JOB_CNT_W-1:0] job_cnt
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t           r_state;
    arb_state_t           w_next;
    logic [IDXW-1:0]      r_ptr;
    logic [IDXW-1:0]      r_gnt;
    logic [IDXW-1:0]      w_gnt;
    logic                 w_any;
    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic [W-1:0]         r_res;
    logic [JOB_CNT_W-1:0] r_cnt;

    gcd_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .i_req    (req_valid),
        .i_rr_ptr (r_ptr),
        .o_gnt    (w_gnt),
        .o_any    (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = START;
            START:   w_next = WAIT;
            WAIT:    if (eng_res_rdy) w_next = RESP;
            RESP:    if (rsp_ready[r_gnt]) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The grant pulse is combinational from req_valid, so it is gated while reset is held.
    always_comb begin
        req_ready     = '0;
        rsp_valid     = '0;
        eng_start     = 1'b0;
        eng_res_fetch = 1'b0;
        busy          = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_any && rst_n) req_ready[w_gnt] = 1'b1;
            end
            START:   eng_start = 1'b1;
            WAIT:    eng_res_fetch = eng_res_rdy;
            RESP:    rsp_valid[r_gnt] = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_gnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_cnt <= '0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_gnt <= w_gnt;
                r_a   <= req_a[w_gnt*W +: W];
                r_b   <= req_b[w_gnt*W +: W];
            end
            if (r_state == WAIT && eng_res_rdy) begin
                r_res <= eng_res;
            end
            if (r_state == RESP && rsp_ready[r_gnt]) begin
                r_ptr <= (r_gnt == IDXW'(NREQ - 1)) ? '0 : r_gnt + IDXW'(1);
                r_cnt <= r_cnt + JOB_CNT_W'(1);
            end
        end
    end

    assign eng_a   = r_a;
    assign eng_b   = r_b;
    assign rsp_res = r_res;
    assign job_cnt = r_cnt;

endmodule

// File: doc/gcd_arbiter.md
GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one gcd engine (2..8).
REQ-002 Parameter W, default 8, operand and result width; matches the engine's 8-bit a/b/res.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NREQ  requester i has an operand pair pending.
REQ-006 req_a  input  NREQ*W  operand a of requester i, at bits [i*W +: W].
REQ-007 req_b  input  NREQ*W  operand b of requester i, at bits [i*W +: W].
REQ-008 req_ready  output  NREQ  one-hot, one-cycle pulse; requester i's pair is accepted this cycle.
REQ-009 rsp_valid  output  NREQ  one-hot; result for requester i is on rsp_res.
REQ-010 rsp_res  output  W  gcd result.
REQ-011 rsp_ready  input  NREQ  requester i consumes the result.
REQ-012 eng_a, eng_b  output  W each  operands to the engine.
REQ-013 eng_start  output  1  one-cycle start pulse to the engine.
REQ-014 eng_res_rdy  input  1  engine result valid; held until fetched.
REQ-015 eng_res  input  W  engine result.
REQ-016 eng_res_fetch  output  1  one-cycle pulse acknowledging the engine result.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 job_cnt  output  16  number of completed jobs; wraps from 0xFFFF to 0.

Function
REQ-019 The FSM SHALL have four states: IDLE, START, WAIT, RESP.
REQ-020 IDLE: if any req_valid is high, grant g = first requester with req_valid set, searching from rr_ptr upward modulo NREQ; pulse req_ready[g]; latch req_a/req_b of g into operand registers; latch g; go to START.
REQ-021 IDLE with no req_valid: remain in IDLE; all pulse outputs low.
REQ-022 START: eng_start=1 for exactly one cycle; go to WAIT.
REQ-023 eng_a/eng_b SHALL equal the latched operands from START through the WAIT exit.
REQ-024 WAIT: when eng_res_rdy=1, latch eng_res; pulse eng_res_fetch for one cycle; go to RESP. Otherwise remain in WAIT, with no timeout.
REQ-025 eng_res_rdy SHALL be ignored in IDLE, START and RESP.
REQ-026 RESP: rsp_valid[g]=1 and rsp_res = latched result, both held stable.
REQ-027 RESP exit: when rsp_ready[g]=1, set rr_ptr=(g+1) mod NREQ, increment job_cnt, go to IDLE. rsp_ready on any other bit is ignored.
REQ-028 At most one job SHALL be in flight; no req_ready pulse may occur outside IDLE.
REQ-029 Minimum latency: accept at cycle T, eng_start at T+1, rsp_valid at E+1 (E is the first cycle eng_res_rdy is seen in WAIT), next accept at R+1 (R is the rsp_ready cycle).
REQ-030 A requester that deasserts req_valid before its grant is not served; nothing is latched for it.
REQ-031 Operands of 0 SHALL be forwarded unchanged; the engine result is returned as-is.

Reset
REQ-032 On rst_n=0, at any time including mid-job, the block SHALL immediately enter IDLE with rr_ptr=0, job_cnt=0, and all outputs 0: req_ready, rsp_valid, rsp_res, eng_a, eng_b, eng_start, eng_res_fetch, busy.
REQ-033 A job interrupted by reset is dropped, with no response; the engine shares rst_n.

Structure
REQ-034 Package gcd_arb_pkg SHALL hold the state encoding (IDLE=0, START=1, WAIT=2, RESP=3) and the job_cnt width constant.
REQ-035 The round-robin search SHALL be the combinational sub-module gcd_rr_pick (inputs: req vector, rr_ptr; outputs: grant index, any).
REQ-036 The gcd engine is instantiated outside gcd_arbiter; the bench connects the engine's a, b, start, res_fetch, res_rdy and res to the eng_* ports.

Verification
REQ-037 Single request: req 2 sends a=48, b=18 -> req_ready[2] pulses, eng_start one cycle later, rsp_valid[2] with rsp_res=6, job_cnt=1.
REQ-038 All four requesters valid from reset, rsp_ready tied high -> grants in order 0,1,2,3, one eng_start per job, job_cnt=4.
REQ-039 Fairness: after serving req 1, reqs 0 and 1 valid -> next grant is 0 (search starts at rr_ptr=2).
REQ-040 Backpressure: rsp_ready[g] low for 10 cycles -> rsp_valid[g] and rsp_res held, no eng_start or req_ready during that time.
REQ-041 Reset in WAIT (a=255, b=17) -> all outputs 0 next cycle, rr_ptr=0; after release, req 3 with a=0, b=9 returns rsp_res=9.
REQ-042 eng_res_rdy forced high during START -> ignored; eng_res_fetch pulses exactly once per job.
